// File: rtl/shift_pkg.sv
// Shared definitions for the shifter and the two-requester shift arbiter.
package shift_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        op;
    logic              id;
  } operand_t;

endpackage

// File: rtl/shifter.sv
// 16-bit barrel shifter: rotate left, shift left, arithmetic and logical shift right.
module shifter
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] In,
  input  logic [CNT_W-1:0]  Cnt,
  input  logic [1:0]        Op,
  output logic [DATA_W-1:0] Out
);

  logic [CNT_W:0] rot_back;

  // Right-hand part of the rotate; Cnt=0 gives a shift of 16, which clears it.
  assign rot_back = 5'(DATA_W) - {1'b0, Cnt};

  always_comb begin
    Out = In;
    unique case (Op)
      OP_ROL:  Out = (In << Cnt) | (In >> rot_back);
      OP_SLL:  Out = In << Cnt;
      OP_SRA:  Out = $signed(In) >>> Cnt;
      OP_SRL:  Out = In >> Cnt;
      default: Out = In;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin sharing of one shifter between two valid/ready requesters,
// with a held, id-tagged response register.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_in,
  input  logic [CNT_W-1:0]  req0_cnt,
  input  logic [1:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_in,
  input  logic [CNT_W-1:0]  req1_cnt,
  input  logic [1:0]        req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_out,
  output logic              rsp_id,
  output logic              busy
);

  state_t            state_reg;
  operand_t          opnd_reg;
  operand_t          opnd_next;
  logic              prio_reg;
  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_out_reg;
  logic              rsp_id_reg;
  logic [DATA_W-1:0] shift_out;

  logic window;
  logic grant0;
  logic grant1;
  logic accept;

  // rst_n is folded in so neither ready can rise while reset is held.
  assign window = rst_n && ((state_reg == IDLE) || ((state_reg == DONE) && rsp_ready));
  assign grant0 = req0_valid && (!req1_valid || !prio_reg);
  assign grant1 = req1_valid && (!req0_valid ||  prio_reg);

  assign req0_ready = window && grant0;
  assign req1_ready = window && grant1;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    opnd_next = '{data: req0_in, cnt: req0_cnt, op: req0_op, id: 1'b0};
    if (grant1) begin
      opnd_next = '{data: req1_in, cnt: req1_cnt, op: req1_op, id: 1'b1};
    end
  end

  shifter u_shifter (
    .In  (opnd_reg.data),
    .Cnt (opnd_reg.cnt),
    .Op  (opnd_reg.op),
    .Out (shift_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      opnd_reg      <= '0;
      prio_reg      <= RESET_PRIO;
      rsp_valid_reg <= 1'b0;
      rsp_out_reg   <= '0;
      rsp_id_reg    <= 1'b0;
    end else begin
      // The winner goes to the back of the line.
      if (accept) begin
        prio_reg <= req0_ready;
      end
      unique case (state_reg)
        IDLE: begin
          if (accept) begin
            opnd_reg  <= opnd_next;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          rsp_out_reg   <= shift_out;
          rsp_id_reg    <= opnd_reg.id;
          rsp_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            if (accept) begin
              opnd_reg  <= opnd_next;
              state_reg <= EXEC;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_out   = rsp_out_reg;
  assign rsp_id    = rsp_id_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: single requests, alternation, stall and async reset.
module tb_shift_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_in;
  logic [3:0]  req0_cnt;
  logic [1:0]  req0_op;
  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_in;
  logic [3:0]  req1_cnt;
  logic [1:0]  req1_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_out;
  logic        rsp_id;
  logic        busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  shift_arbiter #(.RESET_PRIO(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_in    (req0_in),
    .req0_cnt   (req0_cnt),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_in    (req1_in),
    .req1_cnt   (req1_cnt),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_out    (rsp_out),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit id, input logic [15:0] din, input logic [3:0] cnt,
                         input logic [1:0] op);
    if (id == 1'b0) begin
      req0_in = din; req0_cnt = cnt; req0_op = op; req0_valid = 1'b1;
    end else begin
      req1_in = din; req1_cnt = cnt; req1_op = op; req1_valid = 1'b1;
    end
  endtask

  // One isolated request from IDLE through consumption.
  task automatic do_req(input string tag, input bit id, input logic [15:0] din,
                        input logic [3:0] cnt, input logic [1:0] op, input logic [15:0] exp);
    set_req(id, din, cnt, op);
    #1;
    check({tag, "_ready"}, id ? req1_ready : req0_ready, 16'd1);
    check({tag, "_other_ready"}, id ? req0_ready : req1_ready, 16'd0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check({tag, "_exec_busy"}, busy, 16'd1);
    check({tag, "_exec_valid"}, rsp_valid, 16'd0);
    tick();
    check({tag, "_valid"}, rsp_valid, 16'd1);
    check({tag, "_out"}, rsp_out, exp);
    check({tag, "_id"}, rsp_id, 16'(id));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_consumed"}, rsp_valid, 16'd0);
    check({tag, "_idle"}, busy, 16'd0);
    $display("req %s id=%0d in=%h cnt=%0d op=%0d -> out=%h", tag, id, din, cnt, op, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_in = 16'h0; req0_cnt = 4'd0; req0_op = 2'b00;
    req1_valid = 1'b1; req1_in = 16'h0; req1_cnt = 4'd0; req1_op = 2'b00;
    rsp_ready = 1'b1;

    // Reset state, with both requesters knocking.
    #12;
    check("rst_req0_ready", req0_ready, 16'd0);
    check("rst_req1_ready", req1_ready, 16'd0);
    check("rst_rsp_valid", rsp_valid, 16'd0);
    check("rst_rsp_out", rsp_out, 16'h0000);
    check("rst_rsp_id", rsp_id, 16'd0);
    check("rst_busy", busy, 16'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    do_req("rol1",    1'b0, 16'h8001, 4'd1,  2'b00, 16'h0003);
    do_req("sra15",   1'b1, 16'h8000, 4'd15, 2'b10, 16'hFFFF);
    do_req("srl15",   1'b1, 16'h8000, 4'd15, 2'b11, 16'h0001);
    do_req("sll4",    1'b1, 16'h00FF, 4'd4,  2'b01, 16'h0FF0);
    do_req("rol4",    1'b0, 16'hF00F, 4'd4,  2'b00, 16'h00FF);
    do_req("cnt0rol", 1'b0, 16'hA5C3, 4'd0,  2'b00, 16'hA5C3);
    do_req("cnt0sll", 1'b1, 16'hA5C3, 4'd0,  2'b01, 16'hA5C3);
    do_req("cnt0sra", 1'b0, 16'hA5C3, 4'd0,  2'b10, 16'hA5C3);
    do_req("cnt0srl", 1'b1, 16'hA5C3, 4'd0,  2'b11, 16'hA5C3);

    // Fresh reset so the alternation starts from RESET_PRIO=0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_req(1'b0, 16'h0001, 4'd1, 2'b01);
    set_req(1'b1, 16'h0001, 4'd2, 2'b01);
    rsp_ready = 1'b1;
    #1;
    check("alt_first_req0_ready", req0_ready, 16'd1);
    check("alt_first_req1_ready", req1_ready, 16'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("alt_exec_ready0", req0_ready, 16'd0);
      check("alt_exec_valid", rsp_valid, 16'd0);
      tick();
      check("alt_valid", rsp_valid, 16'd1);
      check("alt_id", rsp_id, 16'(i % 2));
      check("alt_out", rsp_out, (i % 2) ? 16'h0004 : 16'h0002);
      check("alt_next_grant", (i % 2) ? req0_ready : req1_ready, 16'd1);
      $display("alt result %0d id=%0d out=%h", i, rsp_id, rsp_out);
      tick();
    end

    // Last DONE above accepted req0 again; now stall its result.
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    tick();
    set_req(1'b0, 16'h1234, 4'd8, 2'b00);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", rsp_valid, 16'd1);
      check("stall_out", rsp_out, 16'h0002);
      check("stall_id", rsp_id, 16'd0);
      check("stall_req0_ready", req0_ready, 16'd0);
      check("stall_req1_ready", req1_ready, 16'd0);
      tick();
    end
    $display("stall held out=%h for 5 cycles", rsp_out);
    rsp_ready = 1'b1;
    #1;
    check("unstall_req0_ready", req0_ready, 16'd1);
    tick();
    req0_valid = 1'b0;
    rsp_ready = 1'b0;
    check("unstall_exec_valid", rsp_valid, 16'd0);
    tick();
    check("unstall_valid", rsp_valid, 16'd1);
    check("unstall_out", rsp_out, 16'h3412);
    check("unstall_id", rsp_id, 16'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    $display("unstall result out=%h", 16'h3412);

    // req0 was the last winner, so prio now points at req1; reset must restore 0.
    set_req(1'b0, 16'h00F0, 4'd4, 2'b11);
    tick();
    req0_valid = 1'b0;
    check("pre_rst_busy", busy, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 16'd0);
    check("async_rst_valid", rsp_valid, 16'd0);
    set_req(1'b0, 16'h0003, 4'd3, 2'b01);
    set_req(1'b1, 16'h0005, 4'd1, 2'b01);
    #1;
    check("async_rst_ready0", req0_ready, 16'd0);
    tick();
    tick();
    check("post_rst_valid", rsp_valid, 16'd0);
    #2;
    rst_n = 1'b1;
    #1;
    check("post_rst_req0_ready", req0_ready, 16'd1);
    check("post_rst_req1_ready", req1_ready, 16'd0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    check("post_rst_rsp_valid", rsp_valid, 16'd1);
    check("post_rst_rsp_id", rsp_id, 16'd0);
    check("post_rst_rsp_out", rsp_out, 16'h0018);
    $display("post-reset grant id=%0d out=%h", rsp_id, rsp_out);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
